// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer plus stability-counter FSM.
// Optional long-press output enabled by defining DEBOUNCER_HOLD_EN.
//
// state        | meaning
// STABLE_LOW   | accepted level is 0, idle
// WAIT_HIGH    | synchronized input is 1, counting toward acceptance
// STABLE_HIGH  | accepted level is 1, idle
// WAIT_LOW     | synchronized input is 0, counting toward acceptance
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int HOLD_WIDTH      = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy,
  output logic hold
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] cnt, next_cnt;
  logic                 s1, s2;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      STABLE_LOW: begin
        if (s2) begin
          next_state = WAIT_HIGH;
          next_cnt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          next_state = STABLE_LOW;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = STABLE_HIGH;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          next_state = WAIT_LOW;
          next_cnt   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          next_state = STABLE_HIGH;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = STABLE_LOW;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: begin
        next_state = STABLE_LOW;
        next_cnt   = '0;
      end
    endcase
  end

  // busy follows the registered state, so it trails state entry by one edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= STABLE_LOW;
      cnt   <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      s1    <= in;
      s2    <= s1;
      state <= next_state;
      cnt   <= next_cnt;
      out   <= (next_state == STABLE_HIGH) || (next_state == WAIT_LOW);
      busy  <= (state == WAIT_HIGH) || (state == WAIT_LOW);
    end
  end

`ifdef DEBOUNCER_HOLD_EN
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);

  logic [HOLD_WIDTH-1:0] hold_cnt;

  // Only a real return to STABLE_LOW clears; a bounce inside WAIT_LOW keeps counting
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
      hold     <= 1'b0;
    end else if (next_state == STABLE_LOW) begin
      hold_cnt <= '0;
      hold     <= 1'b0;
    end else if ((state == STABLE_HIGH) || (state == WAIT_LOW)) begin
      if (hold_cnt == HOLD_LAST) begin
        hold <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^{HOLD_CYCLES, HOLD_WIDTH};
  assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with short timing parameters.
// Bit i of each mask is the input driven at, or the output expected after, edge i.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in  = 1'b0;
  logic out, busy, hold;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (3),
    .HOLD_CYCLES    (10),
    .HOLD_WIDTH     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out),
    .busy(busy),
    .hold(hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v);
    @(negedge clk);
    in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] in_mask, input int n,
                         input logic [31:0] out_mask, input logic [31:0] busy_mask,
                         input logic [31:0] hold_mask, input bit hchk);
    for (int i = 0; i < n; i++) begin
      tick(in_mask[i]);
      chk($sformatf("%s_out[%0d]", tag, i), {31'd0, out}, {31'd0, out_mask[i]});
      chk($sformatf("%s_busy[%0d]", tag, i), {31'd0, busy}, {31'd0, busy_mask[i]});
`ifdef DEBOUNCER_HOLD_EN
      if (hchk) chk($sformatf("%s_hold[%0d]", tag, i), {31'd0, hold}, {31'd0, hold_mask[i]});
`else
      if (hchk || !hchk) chk($sformatf("%s_hold[%0d]", tag, i), {31'd0, hold}, 32'd0);
`endif
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      chk($sformatf("rst_out[%0d]", i), {31'd0, out}, 32'd0);
      chk($sformatf("rst_busy[%0d]", i), {31'd0, busy}, 32'd0);
      chk($sformatf("rst_hold[%0d]", i), {31'd0, hold}, 32'd0);
    end

    // first post-reset edge samples in=1; out rises after edge 6
    rst = 1'b1;
    run_vec("rst_release", 32'hFFFF_FFFF, 10, 32'h3C0, 32'h078, 32'h0, 1'b0);
    run_vec("release1",    32'h0,         12, 32'h03F, 32'h078, 32'h0, 1'b0);

    run_vec("glitch4", 32'h00F, 12, 32'h000, 32'h078, 32'h0, 1'b1);
    run_vec("glitch5", 32'h01F, 16, 32'h7C0, 32'hF78, 32'h0, 1'b1);

    // pattern 1,0,1,1,0,1 then steady 1: last 0->1 at edge 5, out rises after edge 11
    run_vec("bounce",   32'hFFED, 16, 32'hF800, 32'h0F68, 32'h0, 1'b0);
    run_vec("release2", 32'h0,    12, 32'h03F,  32'h078,  32'h0, 1'b0);

    // reset while qualifying in WAIT_HIGH, then a full restart
    run_vec("pre_rst", 32'h00F, 4, 32'h0, 32'h8, 32'h0, 1'b1);
    rst = 1'b0;
    tick(1'b1);
    chk("midrst_out",  {31'd0, out},  32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    run_vec("restart",  32'h3FF, 10, 32'h3C0, 32'h078, 32'h0, 1'b0);
    run_vec("release3", 32'h0,   12, 32'h03F, 32'h078, 32'h0, 1'b0);

`ifdef DEBOUNCER_HOLD_EN
    run_vec("hold_press",   32'h3FFF_FFFF, 30, 32'h3FFF_FFC0, 32'h078, 32'h3FFF_0000, 1'b1);
    run_vec("hold_bounce",  32'h3FC,       10, 32'h3FF,       32'h018, 32'h3FF,       1'b1);
    run_vec("hold_release", 32'h0,         12, 32'h03F,       32'h078, 32'h03F,       1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Cleans one raw, asynchronous push-button or sensor input into a stable, clock-synchronous level.
- Sits directly upstream of the rising-edge pulse generator: its `out` drives that stage's `in`.
- Provides a 2-flop synchronizer, a stability-counter FSM that rejects bounce and glitches, and a busy flag.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive synchronized-stable cycles needed to accept a new level. Legal range is 2 to 2^CNT_WIDTH.
- CNT_WIDTH, 20: width of the debounce counter.
- HOLD_CYCLES, 100000000: cycles of accepted-high before `hold` asserts. Used only with the optional feature.
- HOLD_WIDTH, 27: width of the hold counter. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low. rst==0 at a clk edge resets the block.
- in  input  1  raw asynchronous button/sensor level.
- out  output  1  debounced level, registered; feeds the edge detector.
- busy  output  1  high while a level change is being qualified (state WAIT_HIGH or WAIT_LOW).
- hold  output  1  long-press indicator. See Optional Feature.

Behaviour:
- Reset (rst==0 at an edge):
  - s1, s2, out, busy, hold, cnt and hold_cnt all go to 0.
  - State goes to STABLE_LOW.
  - Reset takes priority over all other conditions, including mid-qualification; any partial count is discarded.
- Synchronizer: s1<=in, s2<=s1 every edge. The FSM only ever looks at s2.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. `out` is registered: 1 in STABLE_HIGH and WAIT_LOW, else 0.
- STABLE_LOW: if s2==1, go to WAIT_HIGH with cnt<=0; otherwise stay.
- WAIT_HIGH, checks in this priority order at each edge:
  - s2==0: go to STABLE_LOW, cnt<=0 (glitch rejected, out never changed).
  - cnt==DEBOUNCE_CYCLES-1: go to STABLE_HIGH, out<=1, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- STABLE_HIGH and WAIT_LOW mirror STABLE_LOW and WAIT_HIGH with polarity swapped. Accepting low sets out<=0.
- busy is registered: 1 exactly while in WAIT_HIGH or WAIT_LOW.
- Latency: call the first edge sampling a new in level edge 0.
  - out changes after edge DEBOUNCE_CYCLES+2, provided in holds that level through edge DEBOUNCE_CYCLES.
- Glitch threshold:
  - A level held for DEBOUNCE_CYCLES or fewer sampled cycles never changes out.
  - A level held for DEBOUNCE_CYCLES+1 or more sampled cycles always does.
- cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- out changes at most once per qualification. The downstream edge detector therefore sees exactly one rising edge per accepted press.

Optional Feature:
- Macro: DEBOUNCER_HOLD_EN.
- Defined:
  - hold_cnt increments every edge while state is STABLE_HIGH or WAIT_LOW, and saturates at HOLD_CYCLES-1.
  - hold<=1 on the edge where hold_cnt==HOLD_CYCLES-1 is observed.
  - hold_cnt and hold clear on the edge the FSM enters STABLE_LOW.
  - A bounce back inside WAIT_LOW does not clear them.
- Not defined: hold is tied to 0, hold_cnt does not exist, and all other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3, HOLD_CYCLES=10, HOLD_WIDTH=4):
- Reset: hold rst=0 for 3 edges with in=1 → out=0, busy=0, hold=0. Release rst → out rises after edge 6 (edge 0 = first post-reset sample).
- Clean press: in 0→1 held 20 cycles → out=1 after edge 6, busy=1 after edges 3–6 only. Release in held 20 cycles → out=0 six edges later.
- Glitch rejection:
  - in=1 for exactly 4 cycles then 0 → out stays 0, busy pulses then returns 0.
  - Repeat with 5 cycles → out pulses high.
- Bounce: in toggles 1,0,1,1,0,1 then steady 1 → out rises once, six edges after the last 0→1, with no intermediate out toggle.
- Reset mid-qualification: rst=0 while busy=1 in WAIT_HIGH → next edge state STABLE_LOW, out=0, busy=0, cnt=0. After release, a full 4+ cycle qualification restarts from zero.
- DEBOUNCER_HOLD_EN defined:
  - Press held 30 cycles → hold=1 exactly 10 edges after out rose.
  - A 2-cycle low bounce keeps hold=1.
  - A real release → hold=0 on the edge out falls.
  - With the macro undefined, hold=0 throughout.
